// File: rtl/bram_rd_capture.sv
// bram_rd_capture: realigns BRAM read data to the read latency of the tapped
// sequencer, buffers it in a FIFO and presents it as a valid/ready stream
// with a last-word flag. Reports word count, 32-bit sum checksum, a sticky
// overflow flag and a one-cycle done pulse.
//   clk, rst_n            clock, async active-low reset
//   ram_en, ram_addr      sequencer BRAM port tap
//   ram_rd_data           BRAM read data (valid RD_LAT cycles after ram_en)
//   start_addr, rd_len    burst descriptor, stable during a burst
//   m_data/m_valid/m_ready/m_last   output stream (FIFO head)
//   word_cnt, checksum, overflow, done   burst status
module bram_rd_capture #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_rd_data,
  input  logic [31:0] start_addr,
  input  logic [31:0] rd_len,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [15:0] word_cnt,
  output logic [31:0] checksum,
  output logic        overflow,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_e;

  state_e              state_q, state_d;
  logic                ram_en_d1_q;
  logic [RD_LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0]   tag_last_q, tag_last_d;
  logic [32:0]         mem_q [FIFO_DEPTH];
  logic [32:0]         mem_d [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    cnt_q, cnt_d;
  logic [15:0]         word_cnt_q, word_cnt_d;
  logic [31:0]         checksum_q, checksum_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic start_burst, launch, is_last, cap, cap_last, empty, full, push, pop;

  always_comb begin
    start_burst = (state_q == IDLE) & ram_en & ~ram_en_d1_q;
    launch      = start_burst | ((state_q == ACTIVE) & ram_en);
    // 32-bit modular offset so bursts wrapping past the top of the space still terminate
    is_last     = ((ram_addr - start_addr) == (rd_len - 32'd4));
    cap         = tag_vld_q[RD_LAT-1];
    cap_last    = tag_last_q[RD_LAT-1];
    empty       = (cnt_q == '0);
    full        = cnt_q[FIFO_AW];
    pop         = ~empty & m_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    push        = cap & (~full | pop);

    tag_vld_d   = (tag_vld_q << 1)  | RD_LAT'(launch);
    tag_last_d  = (tag_last_q << 1) | RD_LAT'(launch & is_last);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cap_last, ram_rd_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    word_cnt_d = word_cnt_q;
    checksum_d = checksum_q;
    overflow_d = overflow_q;
    if (start_burst) begin
      word_cnt_d = '0;
      checksum_d = '0;
      overflow_d = 1'b0;
    end else if (cap) begin
      if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 16'd1;
      checksum_d = checksum_q + ram_rd_data;
      if (!push) overflow_d = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      IDLE:    if (start_burst) state_d = ACTIVE;
      ACTIVE:  if (cap && cap_last) state_d = FLUSH;
      FLUSH:   if (empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ram_en_d1_q <= 1'b0;
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      word_cnt_q  <= '0;
      checksum_q  <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_en_d1_q <= ram_en;
      tag_vld_q   <= tag_vld_d;
      tag_last_q  <= tag_last_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      word_cnt_q  <= word_cnt_d;
      checksum_q  <= checksum_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  assign m_valid  = ~empty;
  assign m_data   = empty ? '0 : mem_q[rd_ptr_q][31:0];
  assign m_last   = ~empty & mem_q[rd_ptr_q][32];
  assign word_cnt = word_cnt_q;
  assign checksum = checksum_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule
